// File: rtl/wb_register_file.sv
// Write-back stage and architectural register file of the 5-stage pipeline.
//
// Selects the write-back value (load data or ALU result) from the MEM/WB outputs,
// commits it to a 2**ADDR_WIDTH-entry GPR array, and serves two combinational ID-stage
// read ports with same-cycle write-through bypass. A wrapping counter tracks retired writes.
//
// Ports:
//   clk                        rising-edge clock
//   rst_n                      synchronous reset, active low
//   write_back_destination_in  destination GPR index
//   reg_write_in               write enable
//   read_data_in               load data from data memory
//   address_in                 ALU result
//   mem_to_reg_in              1: commit read_data_in, 0: commit address_in
//   read_reg_1 / read_reg_2    ID-stage source indices (rs / rt)
//   read_data_1 / read_data_2  GPR values, with $0 = 0 and write-through bypass
//   write_back_data            selected write-back value, for EX-stage forwarding
//   write_count                retired GPR writes since reset (wraps)

module wb_register_file #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_WIDTH-1:0]  write_back_destination_in,
  input  logic                   reg_write_in,
  input  logic [DATA_WIDTH-1:0]  read_data_in,
  input  logic [DATA_WIDTH-1:0]  address_in,
  input  logic                   mem_to_reg_in,
  input  logic [ADDR_WIDTH-1:0]  read_reg_1,
  input  logic [ADDR_WIDTH-1:0]  read_reg_2,
  output logic [DATA_WIDTH-1:0]  read_data_1,
  output logic [DATA_WIDTH-1:0]  read_data_2,
  output logic [DATA_WIDTH-1:0]  write_back_data,
  output logic [COUNT_WIDTH-1:0] write_count
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]  gpr_q [Depth];
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   wr_en;

  // Not gated by reset: EX-stage forwarding sees the raw MEM/WB selection.
  assign write_back_data = mem_to_reg_in ? read_data_in : address_in;

  // Writes to $0 are architecturally discarded and never counted.
  assign wr_en   = reg_write_in && (write_back_destination_in != '0);
  assign count_d = count_q + COUNT_WIDTH'(1);

  // Reset is checked first so an X on reg_write_in during reset cannot reach state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        gpr_q[i] <= '0;
      end
      count_q <= '0;
    end else if (wr_en) begin
      gpr_q[write_back_destination_in] <= write_back_data;
      count_q                          <= count_d;
    end
  end

  assign write_count = count_q;

  // Priority per port: $0, then same-cycle bypass, then the array. Bypass is
  // suppressed in reset because the pending write will be discarded.
  always_comb begin
    read_data_1 = '0;
    if (rst_n && (read_reg_1 != '0)) begin
      if (reg_write_in && (write_back_destination_in == read_reg_1)) begin
        read_data_1 = write_back_data;
      end else begin
        read_data_1 = gpr_q[read_reg_1];
      end
    end
  end

  always_comb begin
    read_data_2 = '0;
    if (rst_n && (read_reg_2 != '0)) begin
      if (reg_write_in && (write_back_destination_in == read_reg_2)) begin
        read_data_2 = write_back_data;
      end else begin
        read_data_2 = gpr_q[read_reg_2];
      end
    end
  end

endmodule

// File: tb/tb_wb_register_file.sv
module tb_wb_register_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  dest;
  logic        reg_write;
  logic [31:0] rdata;
  logic [31:0] addr;
  logic        m2r;
  logic [4:0]  rr1, rr2;
  logic [31:0] rd1, rd2, wbd;
  logic [15:0] wcnt;

  // Second instance with a narrow counter for the wrap check.
  logic [4:0]  s_dest;
  logic        s_reg_write;
  logic [31:0] s_addr;
  logic [4:0]  s_rr1;
  logic [31:0] s_rd1, s_rd2, s_wbd;
  logic [3:0]  s_wcnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_register_file #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .COUNT_WIDTH(16)
  ) u_dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .write_back_destination_in(dest),
    .reg_write_in             (reg_write),
    .read_data_in             (rdata),
    .address_in               (addr),
    .mem_to_reg_in            (m2r),
    .read_reg_1               (rr1),
    .read_reg_2               (rr2),
    .read_data_1              (rd1),
    .read_data_2              (rd2),
    .write_back_data          (wbd),
    .write_count              (wcnt)
  );

  wb_register_file #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .COUNT_WIDTH(4)
  ) u_dut_small (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .write_back_destination_in(s_dest),
    .reg_write_in             (s_reg_write),
    .read_data_in             (32'h0),
    .address_in               (s_addr),
    .mem_to_reg_in            (1'b0),
    .read_reg_1               (s_rr1),
    .read_reg_2               (5'd0),
    .read_data_1              (s_rd1),
    .read_data_2              (s_rd2),
    .write_back_data          (s_wbd),
    .write_count              (s_wcnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    dest        = '0;
    reg_write   = 1'b0;
    rdata       = '0;
    addr        = 32'h0000_0055;
    m2r         = 1'b0;
    rr1         = 5'd1;
    rr2         = 5'd2;
    s_dest      = '0;
    s_reg_write = 1'b0;
    s_addr      = '0;
    s_rr1       = '0;

    // 1. Reset
    tick();
    tick();
    check("rst_rd1", 64'(rd1), 64'h0);
    check("rst_rd2", 64'(rd2), 64'h0);
    check("rst_wbd_follows", 64'(wbd), 64'h55);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      rr1 = 5'(i);
      rr2 = 5'(31 - i);
      #1;
      check($sformatf("rst_gpr1_%0d", i), 64'(rd1), 64'h0);
      check($sformatf("rst_gpr2_%0d", 31 - i), 64'(rd2), 64'h0);
    end
    check("rst_count", 64'(wcnt), 64'h0);

    // 2. ALU write then read
    dest      = 5'd5;
    reg_write = 1'b1;
    m2r       = 1'b0;
    addr      = 32'h0000_00AA;
    tick();
    reg_write = 1'b0;
    rr1       = 5'd5;
    #1;
    check("alu_rd1", 64'(rd1), 64'hAA);
    check("alu_count", 64'(wcnt), 64'h1);

    // 3. Load write, both ports, bypass
    dest      = 5'd9;
    reg_write = 1'b1;
    m2r       = 1'b1;
    rdata     = 32'hDEAD_BEEF;
    rr1       = 5'd9;
    rr2       = 5'd9;
    #1;
    check("ld_wbd", 64'(wbd), 64'hDEAD_BEEF);
    check("ld_bypass_rd1", 64'(rd1), 64'hDEAD_BEEF);
    check("ld_bypass_rd2", 64'(rd2), 64'hDEAD_BEEF);
    tick();
    reg_write = 1'b0;
    rdata     = 32'h0;
    #1;
    check("ld_rd1", 64'(rd1), 64'hDEAD_BEEF);
    check("ld_rd2", 64'(rd2), 64'hDEAD_BEEF);
    check("ld_count", 64'(wcnt), 64'h2);

    // 4. $0 protection
    dest      = 5'd0;
    reg_write = 1'b1;
    m2r       = 1'b0;
    addr      = 32'hFFFF_FFFF;
    rr1       = 5'd0;
    rr2       = 5'd0;
    #1;
    check("r0_bypass_rd1", 64'(rd1), 64'h0);
    check("r0_bypass_rd2", 64'(rd2), 64'h0);
    tick();
    reg_write = 1'b0;
    #1;
    check("r0_rd1", 64'(rd1), 64'h0);
    check("r0_count", 64'(wcnt), 64'h2);

    // 5. Disabled write: preload GPR7, then present a write with enable low
    dest      = 5'd7;
    reg_write = 1'b1;
    addr      = 32'h0000_0077;
    tick();
    reg_write = 1'b0;
    addr      = 32'h0000_1234;
    rr1       = 5'd7;
    #1;
    check("dis_no_bypass", 64'(rd1), 64'h77);
    check("dis_count_pre", 64'(wcnt), 64'h3);
    tick();
    check("dis_keep", 64'(rd1), 64'h77);
    check("dis_count", 64'(wcnt), 64'h3);

    // 6A. Reset collides with a valid write to GPR3
    rst_n     = 1'b0;
    dest      = 5'd3;
    reg_write = 1'b1;
    addr      = 32'h0000_0033;
    rr1       = 5'd3;
    rr2       = 5'd9;
    #1;
    check("rstc_no_bypass", 64'(rd1), 64'h0);
    check("rstc_rd2_gated", 64'(rd2), 64'h0);
    tick();
    reg_write = 1'bx;
    tick();
    rst_n     = 1'b1;
    reg_write = 1'b0;
    #1;
    check("rstc_gpr3", 64'(rd1), 64'h0);
    check("rstc_gpr9", 64'(rd2), 64'h0);
    rr1 = 5'd5;
    rr2 = 5'd7;
    #1;
    check("rstc_gpr5", 64'(rd1), 64'h0);
    check("rstc_gpr7", 64'(rd2), 64'h0);
    check("rstc_count", 64'(wcnt), 64'h0);

    // 6B. Counter wrap on the 4-bit instance: 17 writes to GPR1..GPR17
    s_reg_write = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      s_dest = 5'(i);
      s_addr = 32'h100 + 32'(i);
      tick();
      if (i == 16) check("wrap_at_16", 64'(s_wcnt), 64'h0);
    end
    s_reg_write = 1'b0;
    s_rr1       = 5'd17;
    #1;
    check("wrap_count", 64'(s_wcnt), 64'h1);
    check("wrap_gpr17", 64'(s_rd1), 64'h111);
    check("wrap_main_untouched", 64'(wcnt), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
